// File: rtl/cmd_dispatcher_pkg.sv
// cmd_dispatcher_pkg: shared opcodes, dispatcher state encodings and FIFO entry width
package cmd_dispatcher_pkg;
  localparam logic [1:0] OPCODE_ENCRYPT = 2'd0;
  localparam logic [1:0] OPCODE_DECRYPT = 2'd1;
  localparam logic [1:0] OPCODE_ADD     = 2'd2;
  localparam logic [1:0] OPCODE_MULT    = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_BUSY} state_t;
  function automatic int entry_width(input int aw);
    return 2 + 3 * aw;
  endfunction
endpackage

// File: rtl/cmd_dispatcher_fifo.sv
// cmd_fifo: parameterised synchronous FIFO with wrapping pointers, head data, count and full
module cmd_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     head,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign full = count == (PTR_WIDTH+1)'(DEPTH);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PTR_WIDTH'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PTR_WIDTH'(1) : rd_ptr;
      count  <= count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
    end
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: buffers host commands and issues them one at a time to the controller (optional DISPATCH_TIMEOUT_EN)
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_PTR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_opcode,
  input  logic [ADDR_WIDTH-1:0]     cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0]     cmd_op2_addr,
  input  logic [ADDR_WIDTH-1:0]     cmd_out_addr,
  output logic                      config_en,
  output logic [1:0]                opcode,
  output logic [ADDR_WIDTH-1:0]     op1_base_addr,
  output logic [ADDR_WIDTH-1:0]     op2_base_addr,
  output logic [ADDR_WIDTH-1:0]     out_base_addr,
  input  logic                      ctrl_done,
  output logic                      busy,
  output logic [FIFO_PTR_WIDTH:0]   fifo_count,
  output logic                      retire,
  output logic [7:0]                retire_count,
  output logic                      timeout_err
);
  localparam int EW = entry_width(ADDR_WIDTH);
  state_t state;
  logic [EW-1:0] head;
  logic full, empty, pop, fin, to_hit;
  cmd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .PTR_WIDTH(FIFO_PTR_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .din   ({cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr}),
    .head  (head),
    .count (fifo_count),
    .full  (full)
  );
  assign cmd_ready = !full;
  assign empty     = fifo_count == '0;
  assign busy      = state != ST_IDLE;
  assign fin       = state == ST_BUSY && (ctrl_done || to_hit);
  assign pop       = !empty && (state == ST_IDLE || fin);
`ifdef DISPATCH_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  assign to_hit = !ctrl_done && tcnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt        <= state == ST_BUSY ? tcnt + TIMEOUT_WIDTH'(1) : '0;
      timeout_err <= timeout_err || (state == ST_BUSY && to_hit);
    end
`else
  logic [TIMEOUT_WIDTH-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state         <= ST_IDLE;
      config_en     <= 1'b0;
      retire        <= 1'b0;
      retire_count  <= '0;
      opcode        <= '0;
      op1_base_addr <= '0;
      op2_base_addr <= '0;
      out_base_addr <= '0;
    end else begin
      state        <= pop ? ST_ISSUE :
                      state == ST_ISSUE  ? ST_SETTLE :
                      state == ST_SETTLE ? ST_BUSY :
                      fin ? ST_IDLE : state;
      config_en    <= pop;
      retire       <= fin;
      retire_count <= fin ? retire_count + 8'd1 : retire_count;
      if (pop) {opcode, op1_base_addr, op2_base_addr, out_base_addr} <= head;
    end
endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Upstream stage of the enclave address controller.
- Accepts host commands (opcode plus three base addresses) over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the controller as a one-cycle configuration pulse, then waits for the controller's done before issuing the next.
- Provides busy, occupancy and retire status to the host.

Parameters:
- ADDR_WIDTH, 10, width of every base address.
- FIFO_DEPTH, 4, number of buffered commands; must be a power of 2.
- FIFO_PTR_WIDTH, 2, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 256, BUSY cycles allowed before timeout (optional feature only).
- TIMEOUT_WIDTH, 9, counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  dispatcher can accept a command.
- cmd_opcode  in  2  `OPCODE_ENCRYPT/DECRYPT/ADD/MULT.
- cmd_op1_addr  in  ADDR_WIDTH  operand 1 base address.
- cmd_op2_addr  in  ADDR_WIDTH  operand 2 base address.
- cmd_out_addr  in  ADDR_WIDTH  output base address.
- config_en  out  1  one-cycle configure pulse to the controller.
- opcode  out  2  opcode to the controller.
- op1_base_addr, op2_base_addr, out_base_addr  out  ADDR_WIDTH each  base addresses to the controller.
- ctrl_done  in  1  done from the controller.
- busy  out  1  a command is in flight (state is not IDLE).
- fifo_count  out  FIFO_PTR_WIDTH+1  buffered commands, 0..FIFO_DEPTH.
- retire  out  1  one-cycle pulse when a command completes or times out.
- retire_count  out  8  retired commands, wraps 255->0.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n=0 at an edge) overrides everything:
  - FIFO is emptied; state goes to IDLE.
  - All outputs are 0, except cmd_ready=1 in the first cycle after reset.
  - A command in flight at reset is dropped; the controller shares rst_n.
- FIFO:
  - Entry is {opcode, op1, op2, out}, 2+3*ADDR_WIDTH bits.
  - cmd_ready = (fifo_count != FIFO_DEPTH). It depends only on full; a pop in the same cycle does not open a slot.
  - A push occurs on any edge where cmd_valid && cmd_ready.
  - Push and pop in the same cycle leaves the count unchanged and the data ordering intact.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, SETTLE, BUSY.
  - IDLE: if fifo_count != 0, go to ISSUE on the next edge. On that edge, load opcode and the three base-address output registers from the FIFO head and pop the head. ctrl_done is ignored in IDLE, because the controller does not clear done on reset.
  - ISSUE: config_en=1 for exactly this one cycle; the controller samples it at the closing edge. Next state is SETTLE.
  - SETTLE: one cycle. ctrl_done is ignored here because the controller clears done at the ISSUE edge. Next state is BUSY.
  - BUSY: when ctrl_done=1, pulse retire for one cycle and increment retire_count. Then go to ISSUE if the FIFO is non-empty (head loaded and popped on the same edge), otherwise to IDLE.
- Latency:
  - A push into an empty FIFO in an idle dispatcher at edge t gives ISSUE (config_en high) from edge t+1 to t+2.
  - BUSY is entered at edge t+3.
  - Back-to-back commands: config_en is reasserted on the cycle immediately after the retire edge.
- opcode and base-address outputs hold their values between ISSUEs.
- busy = (state != IDLE).
- Opcode values are passed through unchecked.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_WIDTH-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with no ctrl_done: set timeout_err (sticky until reset), pulse retire, increment retire_count, and leave BUSY by the same rule as a normal retire.
  - If ctrl_done and the timeout hit occur in the same cycle, done wins and timeout_err is not set.
- Undefined: timeout_err is tied 0, no counter exists, and BUSY waits indefinitely.

Decomposition:
- Shared defines header holds:
  - `OPCODE_ENCRYPT/DECRYPT/ADD/MULT (same values as the controller uses).
  - Dispatcher state encodings.
  - The FIFO entry width expression.
- One sub-module: cmd_fifo. It is a parameterised synchronous FIFO with push, pop, head data, count and full, and it carries the pointer wrap logic.

Test Plan:
- Single ADD {op1=0x010, op2=0x020, out=0x030} pushed at edge 5 -> config_en high only in cycle 6 with those addresses; busy=1; ctrl_done at edge 20 -> retire pulse, retire_count=1, IDLE.
- Push 5 commands back-to-back with ctrl_done held low -> cmd_ready drops after the 4th buffered command (1 issued plus 4 queued). Each completion then issues the next in the cycle after retire. Order is preserved, checked by op1 values 1..5.
- Stale ctrl_done=1 held from reset through the first ISSUE/SETTLE -> no retire until BUSY; the first retire occurs in the first BUSY cycle with done=1.
- Reset asserted during BUSY with 2 commands queued -> next cycle: fifo_count=0, busy=0, config_en=0, retire_count=0.
- retire_count wrap: 256 completed commands -> retire_count=0.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=8: ctrl_done never asserted -> retire after 8 BUSY cycles and timeout_err=1 sticky. Repeat with done on exactly the 8th cycle -> timeout_err stays 0.
